// File: rtl/restoring_divider_20bit_if.sv
// Purpose : operand/result bundle between the solver controller and the 20-bit divider.
// Latency : n/a (wires only).
// Backpressure: start is only honoured while busy is low; a refused start is simply lost.
//
// Signals:
//   start      controller -> divider  request, sampled only while idle
//   dividend   controller -> divider  signed numerator, sampled on the accepting edge
//   divisor    controller -> divider  signed denominator, sampled on the accepting edge
//   busy       divider -> controller  division in flight
//   done       divider -> controller  one-cycle pulse, results valid this cycle
//   quotient   divider -> controller  signed quotient, truncated toward zero
//   remainder  divider -> controller  signed remainder, sign of dividend (or zero)
//   dbz        divider -> controller  divide-by-zero flag for the last result
//   v          divider -> controller  overflow flag for the last result
interface restoring_divider_20bit_if;
    logic        start;
    logic [19:0] dividend;
    logic [19:0] divisor;
    logic        busy;
    logic        done;
    logic [19:0] quotient;
    logic [19:0] remainder;
    logic        dbz;
    logic        v;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz, v
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz, v
    );
endinterface

// File: rtl/restoring_divider_20bit.sv
// Purpose : 20-bit signed restoring divider, one quotient bit per cycle, with dbz/overflow flags.
// Latency : fixed 22 cycles from the accepting edge to the done cycle, including dbz/overflow.
// Backpressure: busy high while in flight; start during busy is dropped, not queued.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any division and clears all results
//   bus  slave side of restoring_divider_20bit_if (start/operands in, busy/done/results out)
module restoring_divider_20bit (
    input  logic                        clk,
    input  logic                        rst,
    restoring_divider_20bit_if.slave    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [4:0] LAST_ITER = 5'd19;

    logic [1:0]  state_q,    state_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic [19:0] rem_q,      rem_d;       // partial remainder magnitude
    logic [19:0] dvd_q,      dvd_d;       // dividend magnitude, shifted out as quotient bits shift in
    logic [19:0] dsr_q,      dsr_d;       // divisor magnitude
    logic [19:0] orig_q,     orig_d;      // raw dividend, returned as remainder on divide-by-zero
    logic        neg_dvd_q,  neg_dvd_d;
    logic        neg_dsr_q,  neg_dsr_d;
    logic        dbz_pend_q, dbz_pend_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [19:0] quo_q,      quo_d;
    logic [19:0] rmd_q,      rmd_d;
    logic        dbz_q,      dbz_d;
    logic        v_q,        v_d;

    // Unsigned 20-bit magnitudes: |-524288| = 0x80000 fits without a 21st bit
    // because the value is treated as unsigned from here on.
    logic [19:0] dvd_abs;
    logic [19:0] dsr_abs;
    assign dvd_abs = bus.dividend[19] ? (~bus.dividend + 20'd1) : bus.dividend;
    assign dsr_abs = bus.divisor[19]  ? (~bus.divisor  + 20'd1) : bus.divisor;

    // Shift step and trial subtract. With a non-zero divisor the partial
    // remainder stays below the divisor (<= 2^19), so the shifted value fits in
    // 20 bits and bit 20 of the 21-bit difference is a clean borrow flag.
    // A zero divisor produces garbage here, but those results are overridden in FIX.
    logic [20:0] rem_shift;
    logic [20:0] trial;
    logic        trial_ok;
    assign rem_shift = {rem_q, dvd_q[19]};
    assign trial     = rem_shift - {1'b0, dsr_q};
    assign trial_ok  = ~trial[20];

    // Sign fix-up of the magnitudes for the final result.
    logic [19:0] quo_signed;
    logic [19:0] rem_signed;
    assign quo_signed = (neg_dvd_q ^ neg_dsr_q) ? (~dvd_q + 20'd1) : dvd_q;
    assign rem_signed = neg_dvd_q ? (~rem_q + 20'd1) : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        orig_d     = orig_q;
        neg_dvd_d  = neg_dvd_q;
        neg_dsr_d  = neg_dsr_q;
        dbz_pend_d = dbz_pend_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quo_d      = quo_q;
        rmd_d      = rmd_q;
        dbz_d      = dbz_q;
        v_d        = v_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    neg_dvd_d  = bus.dividend[19];
                    neg_dsr_d  = bus.divisor[19];
                    dvd_d      = dvd_abs;
                    dsr_d      = dsr_abs;
                    orig_d     = bus.dividend;
                    rem_d      = 20'd0;
                    cnt_d      = 5'd0;
                    dbz_pend_d = (bus.divisor == 20'd0);
                    ovf_pend_d = (bus.dividend == 20'h80000) && (bus.divisor == 20'hFFFFF);
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end
            end

            S_CALC: begin
                rem_d = trial_ok ? trial[19:0] : rem_shift[19:0];
                dvd_d = {dvd_q[18:0], trial_ok};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (dbz_pend_q) begin
                    // Saturate toward the dividend's sign; hand the dividend back unchanged.
                    quo_d = neg_dvd_q ? 20'h80000 : 20'h7FFFF;
                    rmd_d = orig_q;
                    dbz_d = 1'b1;
                    v_d   = 1'b0;
                end else if (ovf_pend_q) begin
                    // -524288 / -1 has no 20-bit representation; saturate positive.
                    quo_d = 20'h7FFFF;
                    rmd_d = 20'd0;
                    dbz_d = 1'b0;
                    v_d   = 1'b1;
                end else begin
                    quo_d = quo_signed;
                    rmd_d = rem_signed;
                    dbz_d = 1'b0;
                    v_d   = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            rem_q      <= 20'd0;
            dvd_q      <= 20'd0;
            dsr_q      <= 20'd0;
            orig_q     <= 20'd0;
            neg_dvd_q  <= 1'b0;
            neg_dsr_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quo_q      <= 20'd0;
            rmd_q      <= 20'd0;
            dbz_q      <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            orig_q     <= orig_d;
            neg_dvd_q  <= neg_dvd_d;
            neg_dsr_q  <= neg_dsr_d;
            dbz_pend_q <= dbz_pend_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quo_q      <= quo_d;
            rmd_q      <= rmd_d;
            dbz_q      <= dbz_d;
            v_q        <= v_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.dbz       = dbz_q;
    assign bus.v         = v_q;

endmodule

// File: tb/tb_restoring_divider_20bit.sv
// Purpose : directed self-checking bench for restoring_divider_20bit.
// Latency : checks the fixed 22-cycle start-to-done latency on every division.
// Backpressure: exercises start while busy, start held high and reset mid-operation.
module tb_restoring_divider_20bit;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    restoring_divider_20bit_if bus ();

    restoring_divider_20bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and wait (bounded) for done. lat counts edges from the
    // accepting edge (1) to the edge that raises done; -1 means timeout.
    task automatic run_div(input logic [19:0] dd, input logic [19:0] ds,
                           output logic [19:0] q, output logic [19:0] r,
                           output logic fz, output logic fv, output int lat);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = ds;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 20'h5A5A5;
        bus.divisor  = 20'h00003;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
        q  = bus.quotient;
        r  = bus.remainder;
        fz = bus.dbz;
        fv = bus.v;
    endtask

    // Truncating signed division reference.
    function automatic void model(input logic [19:0] dd, input logic [19:0] ds,
                                  output logic [19:0] q, output logic [19:0] r,
                                  output logic fz, output logic fv);
        int a;
        int b;
        a  = int'($signed(dd));
        b  = int'($signed(ds));
        fz = 1'b0;
        fv = 1'b0;
        if (b == 0) begin
            fz = 1'b1;
            q  = (a < 0) ? 20'h80000 : 20'h7FFFF;
            r  = dd;
        end else if (a == -524288 && b == -1) begin
            fv = 1'b1;
            q  = 20'h7FFFF;
            r  = 20'd0;
        end else begin
            q  = 20'(a / b);
            r  = 20'(a % b);
        end
    endfunction

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 20'd0;
        bus.divisor  = 20'd0;
        tick();
        tick();
        tests++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz, bus.v} !== 44'd0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b v=%b, want all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz, bus.v);
        end
        // rst and start on the same edge: rst wins
        bus.start    = 1'b1;
        bus.dividend = 20'd9;
        bus.divisor  = 20'd3;
        tick();
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_beats_start: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int busy_bad;
        busy_bad     = 0;
        bus.start    = 1'b1;
        bus.dividend = 20'h00064;
        bus.divisor  = 20'h00007;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
            if (c < 21) tick();
        end
        tests++;
        if (busy_bad != 0) begin
            fails++;
            $display("FAIL basic_busy: %0d cycles with busy!=1 or early done, want 0", busy_bad);
        end
        tick();
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_cycle22: done=%b busy=%b, want done=1 busy=0", bus.done, bus.busy);
        end
        tests++;
        if ({bus.quotient, bus.remainder, bus.dbz, bus.v} !== {20'h0000E, 20'h00002, 2'b00}) begin
            fails++;
            $display("FAIL basic_100_7: q=%h r=%h dbz=%b v=%b, want q=0000e r=00002 dbz=0 v=0",
                     bus.quotient, bus.remainder, bus.dbz, bus.v);
        end
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.quotient !== 20'h0000E) begin
            fails++;
            $display("FAIL basic_pulse_hold: done=%b q=%h, want done=0 q=0000e", bus.done, bus.quotient);
        end
    endtask

    // Directed table: signs and boundary cases with hand-computed results.
    task automatic test_signs_bounds();
        logic [19:0] vdd [7] = '{20'hFFF9C, 20'h00064, 20'h80000, 20'h80000, 20'h00005, 20'hFFFFB, 20'h7FFFF};
        logic [19:0] vds [7] = '{20'h00007, 20'hFFFF9, 20'h00001, 20'hFFFFF, 20'h00000, 20'h00000, 20'h00002};
        logic [19:0] eq  [7] = '{20'hFFFF2, 20'hFFFF2, 20'h80000, 20'h7FFFF, 20'h7FFFF, 20'h80000, 20'h3FFFF};
        logic [19:0] er  [7] = '{20'hFFFFE, 20'h00002, 20'h00000, 20'h00000, 20'h00005, 20'hFFFFB, 20'h00001};
        logic [1:0]  ef  [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
        logic [19:0] q;
        logic [19:0] r;
        logic        fz;
        logic        fv;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            run_div(vdd[i], vds[i], q, r, fz, fv, lat);
            tests++;
            if ({q, r, fz, fv} !== {eq[i], er[i], ef[i]} || lat != 22) begin
                fails++;
                $display("FAIL vector_%0d %h/%h: q=%h r=%h dbz=%b v=%b lat=%0d, want q=%h r=%h dbz=%b v=%b lat=22",
                         i, vdd[i], vds[i], q, r, fz, fv, lat, eq[i], er[i], ef[i][1], ef[i][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int pos [3];
        pulses       = 0;
        bus.start    = 1'b1;
        bus.dividend = 20'd12;
        bus.divisor  = 20'd4;
        tick();
        for (int c = 2; c <= 66; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                if (pulses < 3) pos[pulses] = c;
                pulses++;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (pulses != 3 || pos[0] != 22 || pos[1] != 44 || pos[2] != 66) begin
            fails++;
            $display("FAIL back_to_back_pulses: count=%0d at %0d,%0d,%0d, want 3 at 22,44,66",
                     pulses, pos[0], pos[1], pos[2]);
        end
        tests++;
        if (bus.quotient !== 20'd3 || bus.remainder !== 20'd0) begin
            fails++;
            $display("FAIL back_to_back_result: q=%h r=%h, want 00003 00000", bus.quotient, bus.remainder);
        end
        for (int c = 0; c < 25; c++) tick();
    endtask

    task automatic test_ignore_start();
        int pulses;
        int first;
        pulses       = 0;
        first        = -1;
        bus.start    = 1'b1;
        bus.dividend = 20'd200;
        bus.divisor  = 20'd9;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 20'h12345;
        bus.divisor  = 20'h00002;
        for (int c = 2; c <= 60; c++) begin
            bus.start = (c == 10);
            tick();
            if (bus.done === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    tests++;
                    if (bus.quotient !== 20'd22 || bus.remainder !== 20'd2) begin
                        fails++;
                        $display("FAIL ignore_operand_change: q=%h r=%h, want 00016 00002",
                                 bus.quotient, bus.remainder);
                    end
                end
                pulses++;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (pulses != 1 || first != 22) begin
            fails++;
            $display("FAIL ignore_busy_start: %0d done pulses, first at %0d, want 1 at 22", pulses, first);
        end
    endtask

    task automatic test_reset_midop();
        logic [19:0] q;
        logic [19:0] r;
        logic        fz;
        logic        fv;
        int          lat;
        int          pulses;
        pulses       = 0;
        bus.start    = 1'b1;
        bus.dividend = 20'd1000;
        bus.divisor  = 20'd3;
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 12; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz, bus.v} !== 44'd0) begin
            fails++;
            $display("FAIL reset_midop_state: busy=%b done=%b q=%h r=%h dbz=%b v=%b, want all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz, bus.v);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL reset_midop_no_done: %0d done pulses, want 0", pulses);
        end
        run_div(20'd1000, 20'd3, q, r, fz, fv, lat);
        tests++;
        if (q !== 20'h0014D || r !== 20'h00001 || lat != 22) begin
            fails++;
            $display("FAIL reset_midop_restart: q=%h r=%h lat=%0d, want 0014d 00001 22", q, r, lat);
        end
    endtask

    task automatic test_model_sweep();
        logic [19:0] corners [6] = '{20'h00000, 20'h00001, 20'hFFFFF, 20'h7FFFF, 20'h80000, 20'h00007};
        logic [19:0] dd;
        logic [19:0] ds;
        logic [19:0] q;
        logic [19:0] r;
        logic [19:0] eq;
        logic [19:0] er;
        logic        fz;
        logic        fv;
        logic        ez;
        logic        ev;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            if (i < 36) begin
                dd = corners[i / 6];
                ds = corners[i % 6];
            end else begin
                dd = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 20'($urandom);
                ds = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 20'($urandom_range(0, 2047));
                if ($urandom_range(0, 1) == 1) ds = ~ds + 20'd1;
            end
            model(dd, ds, eq, er, ez, ev);
            run_div(dd, ds, q, r, fz, fv, lat);
            tests++;
            if ({q, r, fz, fv} !== {eq, er, ez, ev} || lat != 22) begin
                fails++;
                $display("FAIL sweep_%0d %h/%h: q=%h r=%h dbz=%b v=%b lat=%0d, want q=%h r=%h dbz=%b v=%b lat=22",
                         i, dd, ds, q, r, fz, fv, lat, eq, er, ez, ev);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_signs_bounds();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        test_model_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
